// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Widths for the default geometry; parameterised instances derive their own.
  localparam int DEF_ADDR_BITS  = 14;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_SETS       = 8;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int BLK_W = DEF_ADDR_BITS - OFF_W - 2;
  localparam int TAG_W = BLK_W - IDX_W;

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag array and line data, with async read by index.
module icache_way
  import icache_pkg::*;
#(
  parameter  int SETS = 8,
  parameter  int TW   = 6,
  parameter  int LB   = 256,
  localparam int IW   = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [LB-1:0] rd_line,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [LB-1:0] wr_line,
  input  logic          inv_en,
  input  logic [IW-1:0] inv_idx
);

  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_mem  [SETS];
  logic [LB-1:0]   data_mem [SETS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset)       valid          <= '0;
    else if (inv_en) valid[inv_idx] <= 1'b0;
    else if (wr_en)  valid[wr_idx]  <= 1'b1;
  end

  // Tag/data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

endmodule

// File: rtl/instruction_cache_assoc.sv
// 1/2-way set-associative instruction cache: hit path, line fill over a
// ready handshake, LRU replacement and a one-set-per-cycle flush.
module instruction_cache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_BITS  = 14,
  parameter int LINE_WORDS = 8,
  parameter int SETS       = 8,
  parameter int WAYS       = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [31:0]                                addr,
  output logic [31:0]                                out,
  output logic                                       clk_stall,
  output logic [ADDR_BITS-$clog2(LINE_WORDS*4)-1:0]  mem_block_addr,
  output logic                                       readmem,
  input  logic                                       mem_ready,
  input  logic [32*LINE_WORDS-1:0]                   new_line,
  input  logic                                       data_cache_busy,
  input  logic                                       flush
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int BW = ADDR_BITS - OW - 2;
  localparam int TW = BW - IW;
  localparam int LB = 32 * LINE_WORDS;

  state_t          state, state_n;
  logic            stall_n, readmem_n, fpend_n, victim_n;
  logic            flush_pending, victim;
  logic [BW-1:0]   blk_n;
  logic [IW-1:0]   flush_cnt, cnt_n;
  logic [OW-1:0]   addr_buf, abuf_n;
  logic [LB-1:0]   line_buf, lbuf_n;

  logic [OW-1:0]   off_in;
  logic [IW-1:0]   idx_in;
  logic [TW-1:0]   tag_in;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;

  logic [WAYS-1:0]         way_valid, hit_vec, way_we;
  logic [WAYS-1:0][TW-1:0] way_tag;
  logic [WAYS-1:0][LB-1:0] way_line;
  logic                    hit, hit_way, inv_way, victim_c;
  logic                    fill_we, inv_en;

  logic [SETS-1:0] lru;
  logic            lru_we, lru_val;
  logic [IW-1:0]   lru_idx;

  // Upper address bits alias and byte-lane bits are always zero.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_BITS], addr[1:0]};

  assign off_in   = addr[OW+1:2];
  assign idx_in   = addr[OW+2 +: IW];
  assign tag_in   = addr[ADDR_BITS-1:OW+2+IW];
  assign fill_idx = mem_block_addr[IW-1:0];
  assign fill_tag = mem_block_addr[BW-1:IW];

  genvar w;
  generate
    for (w = 0; w < WAYS; w++) begin : g_way
      assign hit_vec[w] = way_valid[w] && (way_tag[w] == tag_in);
      assign way_we[w]  = fill_we && (victim == 1'(w));

      icache_way #(.SETS(SETS), .TW(TW), .LB(LB)) u_way (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_in),
        .rd_valid (way_valid[w]),
        .rd_tag   (way_tag[w]),
        .rd_line  (way_line[w]),
        .wr_en    (way_we[w]),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_line  (new_line),
        .inv_en   (inv_en),
        .inv_idx  (flush_cnt)
      );
    end

    // lru[set] names the least recently used way of that set.
    if (WAYS == 2) begin : g_lru
      always_ff @(posedge clk) begin
        if (reset)       lru            <= '0;
        else if (inv_en) lru[flush_cnt] <= 1'b0;
        else if (lru_we) lru[lru_idx]   <= lru_val;
      end
    end else begin : g_no_lru
      assign lru = '0;
    end
  endgenerate

  assign hit = |hit_vec;

  always_comb begin
    hit_way = 1'b0;
    inv_way = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_way = 1'(i);
      if (!way_valid[i]) inv_way = 1'(i);
    end
  end

  assign victim_c = (&way_valid) ? lru[idx_in] : inv_way;
  assign out      = line_buf[32*addr_buf +: 32];

  always_comb begin
    state_n   = state;
    stall_n   = clk_stall;
    readmem_n = readmem;
    blk_n     = mem_block_addr;
    fpend_n   = flush_pending;
    victim_n  = victim;
    cnt_n     = flush_cnt;
    abuf_n    = addr_buf;
    lbuf_n    = line_buf;
    fill_we   = 1'b0;
    inv_en    = 1'b0;
    lru_we    = 1'b0;
    lru_idx   = idx_in;
    lru_val   = 1'b0;
    case (state)
      IDLE: begin
        if (!data_cache_busy) begin
          if (flush) begin
            stall_n = 1'b1;
            cnt_n   = '0;
            state_n = FLUSH;
          end else begin
            abuf_n = off_in;
            if (hit) begin
              lbuf_n  = way_line[hit_way];
              stall_n = 1'b0;
              lru_we  = 1'b1;
              lru_val = ~hit_way;
            end else begin
              stall_n   = 1'b1;
              readmem_n = 1'b1;
              blk_n     = addr[ADDR_BITS-1:OW+2];
              victim_n  = victim_c;
              state_n   = FILL;
            end
          end
        end
      end
      FILL: begin
        if (flush) fpend_n = 1'b1;
        if (mem_ready) begin
          fill_we   = 1'b1;
          lbuf_n    = new_line;
          lru_we    = 1'b1;
          lru_idx   = fill_idx;
          lru_val   = ~victim;
          readmem_n = 1'b0;
          fpend_n   = 1'b0;
          // A flush seen during the fill runs straight after it, stall held.
          if (flush_pending || flush) begin
            cnt_n   = '0;
            state_n = FLUSH;
          end else begin
            stall_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      FLUSH: begin
        inv_en = 1'b1;
        cnt_n  = flush_cnt + 1'b1;
        if (flush_cnt == IW'(SETS - 1)) begin
          stall_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      clk_stall      <= 1'b0;
      readmem        <= 1'b0;
      mem_block_addr <= '0;
      flush_pending  <= 1'b0;
      victim         <= 1'b0;
      flush_cnt      <= '0;
      addr_buf       <= '0;
      line_buf       <= '0;
    end else begin
      state          <= state_n;
      clk_stall      <= stall_n;
      readmem        <= readmem_n;
      mem_block_addr <= blk_n;
      flush_pending  <= fpend_n;
      victim         <= victim_n;
      flush_cnt      <= cnt_n;
      addr_buf       <= abuf_n;
      line_buf       <= lbuf_n;
    end
  end

endmodule
